// File: rtl/handshake_sender.sv
// Four-phase req/ack sender: captures a payload, raises req, and completes when the synchronised ack returns low.
// Optional abort timer enabled by defining HANDSHAKE_SENDER_TIMEOUT_EN.
module handshake_sender #(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             send,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ack_async,
  output logic             req,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
`ifdef HANDSHAKE_SENDER_TIMEOUT_EN
  output logic             timeout,
`endif
  output logic             done
);

  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("handshake_sender: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_REQ_HI      = 2'd1,
    S_WAIT_ACK_LO = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   w_ack_s;
  logic                   w_capture;
  logic                   w_done_nxt;
  logic                   r_req;
  logic                   r_busy;
  logic                   r_done;
  logic [WIDTH-1:0]       r_data;

`ifdef HANDSHAKE_SENDER_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  // Compared against the pre-increment count so the abort lands exactly TIMEOUT_CYCLES edges after accept.
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  logic             w_timeout_nxt;
`endif

  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A stale ack from the previous transfer blocks a new request.
        if (send && !w_ack_s) begin
          w_state_nxt = S_REQ_HI;
          w_capture   = 1'b1;
        end
      end
      S_REQ_HI: begin
        if (w_ack_s) w_state_nxt = S_WAIT_ACK_LO;
      end
      S_WAIT_ACK_LO: begin
        if (!w_ack_s) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
`ifdef HANDSHAKE_SENDER_TIMEOUT_EN
    w_timeout_nxt = 1'b0;
    // A normal completion on the same edge wins over the abort.
    if (r_state != S_IDLE && w_state_nxt != S_IDLE && r_cnt == CNT_LIM) begin
      w_state_nxt   = S_IDLE;
      w_timeout_nxt = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ack_sync <= '0;
      r_req      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_data     <= '0;
`ifdef HANDSHAKE_SENDER_TIMEOUT_EN
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_async};
      r_req      <= (w_state_nxt == S_REQ_HI);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= w_done_nxt;
      if (w_capture) r_data <= data_in;
`ifdef HANDSHAKE_SENDER_TIMEOUT_EN
      r_timeout <= w_timeout_nxt;
      if (w_capture)              r_cnt <= '0;
      else if (r_state != S_IDLE) r_cnt <= r_cnt + 1'b1;
`endif
    end
  end

  assign req      = r_req;
  assign busy     = r_busy;
  assign done     = r_done;
  assign data_out = r_data;
`ifdef HANDSHAKE_SENDER_TIMEOUT_EN
  assign timeout  = r_timeout;
`endif

endmodule

// File: tb/tb_handshake_sender.sv
// Directed bench for handshake_sender: timed handshake sequence with a payload scoreboard popped on done.
// The abort-timer section is built only when HANDSHAKE_SENDER_TIMEOUT_EN is defined.
module tb_handshake_sender;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
`ifdef HANDSHAKE_SENDER_TIMEOUT_EN
  localparam int TO_CYC = 10;
`else
  localparam int TO_CYC = 255;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             send;
  logic [WIDTH-1:0] data_in;
  logic             ack_async;
  logic             req;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;
`ifdef HANDSHAKE_SENDER_TIMEOUT_EN
  logic             timeout;
`endif

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  logic [WIDTH-1:0] sb[$];

  handshake_sender #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .reset(reset), .send(send), .data_in(data_in),
    .ack_async(ack_async), .req(req), .data_out(data_out), .busy(busy),
`ifdef HANDSHAKE_SENDER_TIMEOUT_EN
    .timeout(timeout),
`endif
    .done(done)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must deliver the oldest accepted payload.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      check("sb_nonempty_on_done", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) check("done_payload", 32'(data_out), 32'(sb.pop_front()));
    end
  end

  // Raise ack, measure req fall latency, drop ack, measure done latency.
  task automatic ack_cycle(input string tag);
    int n;
    @(negedge clk); #1;
    ack_async = 1'b1;
    n = 0;
    while (req !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    check({tag, "_req_fall_lat"}, 32'(n), SYNC + 1);
    check({tag, "_busy_in_wait"}, 32'(busy), 1);
    #1;
    ack_async = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check({tag, "_done_lat"}, 32'(n), SYNC + 1);
    check({tag, "_busy_at_done"}, 32'(busy), 0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dc;
    reset = 1'b1; send = 1'b1; data_in = 8'h11; ack_async = 1'b0;
    // Reset window with a send request that must be ignored
    #12;
    check("rst_req", 32'(req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_data", 32'(data_out), 0);
    #13; reset = 1'b0; send = 1'b0;             // t=25
    #15; send = 1'b1; data_in = 8'hA5;          // t=40
    #15;                                        // t=55
    check("acc_req", 32'(req), 1);
    check("acc_busy", 32'(busy), 1);
    check("acc_data", 32'(data_out), 8'hA5);
    sb.push_back(8'hA5);
    #5;  send = 1'b0;                           // t=60
    #10; send = 1'b1; data_in = 8'h3C;          // t=70, held through busy
    #25; ack_async = 1'b1;                      // t=95
    #40;                                        // t=135
    check("hold_req", 32'(req), 1);
    check("hold_data", 32'(data_out), 8'hA5);
    #20;                                        // t=155
    check("req_fall", 32'(req), 0);
    check("wait_busy", 32'(busy), 1);
    #20; ack_async = 1'b0;                      // t=175
    #40;                                        // t=215
    check("pre_done", 32'(done), 0);
    check("pre_done_busy", 32'(busy), 1);
    #20;                                        // t=235
    check("done_pulse", 32'(done), 1);
    check("done_busy", 32'(busy), 0);
    check("done_req", 32'(req), 0);
    #20;                                        // t=255
    check("b2b_done_low", 32'(done), 0);
    check("b2b_req", 32'(req), 1);
    check("b2b_data", 32'(data_out), 8'h3C);
    sb.push_back(8'h3C);
    #5; send = 1'b0;
    ack_cycle("xfer2");

    // Short ack glitch between edges while idle
    @(negedge clk); #2; ack_async = 1'b1; #5; ack_async = 1'b0;
    repeat (3) @(negedge clk);
    check("glitch_busy", 32'(busy), 0);
    check("glitch_req", 32'(req), 0);

    // Stale ack held high in IDLE blocks send
    ack_async = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    send = 1'b1; data_in = 8'h5A;
    repeat (3) @(negedge clk);
    check("stale_busy", 32'(busy), 0);
    check("stale_req", 32'(req), 0);
    ack_async = 1'b0;
    repeat (SYNC) @(negedge clk);
    check("stale_still_idle", 32'(busy), 0);
    @(negedge clk);
    check("stale_accept_busy", 32'(busy), 1);
    check("stale_accept_data", 32'(data_out), 8'h5A);
    sb.push_back(8'h5A);
    send = 1'b0;
    ack_cycle("xfer3");

    // Reset in the middle of REQ_HI aborts without done
    dc = done_cnt;
    @(negedge clk); send = 1'b1; data_in = 8'h77;
    @(negedge clk); send = 1'b0;
    check("abort_pre_req", 32'(req), 1);
    #3; reset = 1'b1; #1;
    check("abort_req", 32'(req), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_data", 32'(data_out), 0);
    @(negedge clk); reset = 1'b0; send = 1'b1; data_in = 8'hC3;
    @(negedge clk);
    check("post_rst_accept", 32'(busy), 1);
    check("post_rst_data", 32'(data_out), 8'hC3);
    check("abort_no_done", 32'(done_cnt), 32'(dc));
    sb.push_back(8'hC3);
    send = 1'b0;
    ack_cycle("xfer4");

`ifdef HANDSHAKE_SENDER_TIMEOUT_EN
    // Ack never rises: abort after TO_CYC edges
    @(negedge clk); send = 1'b1; data_in = 8'h42;
    @(posedge clk); #2; send = 1'b0;
    check("to_accept", 32'(busy), 1);
    n = 0;
    while (timeout !== 1'b1 && n < 40) begin @(posedge clk); #2; n++; end
    check("to_latency", 32'(n), TO_CYC);
    check("to_req", 32'(req), 0);
    check("to_busy", 32'(busy), 0);
    check("to_done", 32'(done), 0);
    @(posedge clk); #2;
    check("to_one_cycle", 32'(timeout), 0);
`else
    n = 0;
`endif

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);
    check("done_total", 32'(done_cnt), 4 + n * 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/handshake_sender.md
HANDSHAKE_SENDER -- requirements
Module: handshake_sender

Interface
REQ-001 Parameter WIDTH, default 8: payload width in bits.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop stages on the ack synchroniser (minimum 2).
REQ-003 Parameter TIMEOUT_CYCLES, default 255: abort threshold in clocks (used only under REQ-027).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 send  input  1  synchronous request; sampled only when busy=0.
REQ-007 data_in  input  WIDTH  payload captured when send is accepted.
REQ-008 ack_async  input  1  acknowledge from receiving domain; asynchronous to clk.
REQ-009 req  output  1  four-phase request level toward receiver; registered.
REQ-010 data_out  output  WIDTH  captured payload; registered.
REQ-011 busy  output  1  high whenever state is not IDLE; registered.
REQ-012 done  output  1  one-cycle pulse on transfer completion; registered.

Function
REQ-013 ack_async SHALL pass through a SYNC_STAGES-deep flip-flop chain; the last stage (ack_s) is the only ack value used by logic.
REQ-014 The FSM SHALL have exactly three states: IDLE, REQ_HI, WAIT_ACK_LO.
REQ-015 IDLE: on a rising edge with send=1 and ack_s=0 -> capture data_in into data_out, set req=1, busy=1, go to REQ_HI.
REQ-016 IDLE with send=1 and ack_s=1 (stale ack): send SHALL be ignored; state stays IDLE.
REQ-017 REQ_HI: on an edge with ack_s=1 -> req=0, go to WAIT_ACK_LO; otherwise hold req=1 and data_out unchanged.
REQ-018 WAIT_ACK_LO: on an edge with ack_s=0 -> go to IDLE, busy=0, done=1 for exactly that one cycle.
REQ-019 data_out SHALL remain stable from capture until the edge that leaves WAIT_ACK_LO.
REQ-020 send while busy=1 SHALL be ignored, including in the cycle done is asserted.
REQ-021 Latency: req rises on the edge accepting send; req falls SYNC_STAGES+1 edges after ack_async rises (setup met); done asserts SYNC_STAGES+1 edges after ack_async falls.
REQ-022 A back-to-back send presented in the cycle after done SHALL be accepted.
REQ-023 ack_async glitches shorter than one clock period while in IDLE SHALL NOT change state.

Reset
REQ-024 While reset=1, regardless of clk: state=IDLE, req=0, busy=0, done=0, data_out=0, all synchroniser stages=0.
REQ-025 Reset asserted mid-transfer (REQ_HI or WAIT_ACK_LO) SHALL abort immediately with req=0 and no done pulse.
REQ-026 After reset deassertion, the first send SHALL be accepted on the first rising edge where ack_s=0.

Configuration
REQ-027 Macro HANDSHAKE_SENDER_TIMEOUT_EN defined: add output timeout (1 bit, registered, reset 0) and an 8+ bit counter cleared on entering REQ_HI, incremented each cycle in REQ_HI or WAIT_ACK_LO; on reaching TIMEOUT_CYCLES the FSM SHALL go to IDLE, req=0, busy=0, timeout=1 for one cycle, done=0.
REQ-028 Macro undefined: no timeout port, no counter; FSM waits indefinitely in REQ_HI/WAIT_ACK_LO.

Verification (clk period 20, edges at 10, 30, 50, ...)
REQ-029 reset=1 at t=0..25, ack_async=0 -> req=0, busy=0, done=0, data_out=0 throughout; first accepted send at edge t=30 or later.
REQ-030 send=1, data_in=0xA5 at edge t=50; ack_async=1 at t=95; ack_async=0 at t=175 -> req=1 at t=50; data_out=0xA5 from t=50; req=0 at t=150; done=1 for cycle t=230..250; busy=0 from t=230.
REQ-031 Second send with data_in=0x3C during REQ_HI -> ignored; data_out stays 0xA5; next send at edge t=250 accepted with data_out=0x3C.
REQ-032 ack_async=1 held in IDLE, send=1 -> no req, busy stays 0; after ack_async=0 and SYNC_STAGES edges, send accepted.
REQ-033 reset pulse at t=105 during REQ_HI -> req=0 and busy=0 immediately, no done pulse.
REQ-034 HANDSHAKE_SENDER_TIMEOUT_EN defined, TIMEOUT_CYCLES=10, ack never rises -> timeout=1 for one cycle 10 edges after accept; req=0, busy=0, done=0.
